exec_scheduler: RTL and testbench

Single-issue instruction sequencer in front of the execution unit (`execont` family: 2-bit opcode, add/sub/mul over WIDTH-bit operands). It owns the SIZE-entry register file, buffers incoming instructions in a small FIFO, and dispatches one instruction at a time over an enable/ready handshake. On completion it writes the result back to the register file. Instructions retire strictly in order, so no hazard logic is needed.

---
 rtl/exec_scheduler.sv | 155 +++++++++++++++
 tb/tb_exec_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_scheduler.sv
// Single-issue instruction sequencer: instruction FIFO, register file and an
// IDLE/ISSUE/WAIT/WB dispatch FSM that drives an add/sub/mul unit over en/ready.
module exec_scheduler #(
  parameter int WIDTH   = 8,
  parameter int SIZE    = 64,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  localparam int AW     = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_op,
  input  logic [AW-1:0]    instr_dst,
  input  logic [AW-1:0]    instr_src1,
  input  logic [AW-1:0]    instr_src2,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata,
  output logic             exe_en,
  output logic [1:0]       exe_op,
  output logic [WIDTH-1:0] exe_src1,
  output logic [WIDTH-1:0] exe_src2,
  output logic [AW-1:0]    exe_dst,
  input  logic             exe_ready,
  input  logic [WIDTH-1:0] exe_result,
  output logic             busy,
  output logic             done,
  output logic [15:0]      retired,
  output logic             err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_NOP = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;
  state_t state, state_d;

  logic [1:0]       fifo_op   [DEPTH];
  logic [AW-1:0]    fifo_dst  [DEPTH];
  logic [AW-1:0]    fifo_src1 [DEPTH];
  logic [AW-1:0]    fifo_src2 [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [TW-1:0]    tmo_cnt;
  logic [WIDTH-1:0] regfile [SIZE];
  logic [WIDTH-1:0] wb_result;

  logic          push, pop, tmo_hit;
  logic [1:0]    head_op;
  logic [AW-1:0] head_dst, head_src1, head_src2;

  // Readiness depends only on the registered count, so a full FIFO refuses
  // a push even when the FSM pops in the same cycle.
  assign instr_ready = (count < CW'(DEPTH));
  assign push        = instr_valid && instr_ready;
  assign pop         = (state == S_IDLE) && (count != '0);
  assign busy        = (state != S_IDLE) || (count != '0);
  assign host_rdata  = regfile[host_addr];

  assign head_op   = fifo_op[rd_ptr];
  assign head_dst  = fifo_dst[rd_ptr];
  assign head_src1 = fifo_src1[rd_ptr];
  assign head_src2 = fifo_src2[rd_ptr];

  // WAIT lasts at most TIMEOUT cycles: the abort edge is the one on which the
  // count would reach TIMEOUT.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state;
    exe_en  = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) state_d = (head_op == OP_NOP) ? S_WB : S_ISSUE;
      end
      S_ISSUE: begin
        exe_en  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        exe_en = 1'b1;
        if (exe_ready)    state_d = S_WB;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_WB: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tmo_cnt  <= '0;
      retired  <= '0;
      err      <= 1'b0;
      exe_op   <= '0;
      exe_dst  <= '0;
      exe_src1 <= '0;
      exe_src2 <= '0;
      for (int i = 0; i < SIZE; i++) regfile[i] <= '0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + PW'(1);

      // Operands are read at pop time; a writeback on the previous edge is visible.
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        exe_op   <= head_op;
        exe_dst  <= head_dst;
        exe_src1 <= regfile[head_src1];
        exe_src2 <= regfile[head_src2];
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (state == S_ISSUE)     tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + TW'(1);

      if (state == S_WAIT && !exe_ready && tmo_hit) err <= 1'b1;

      if (state == S_WB) begin
        retired <= retired + 16'd1;
        if (exe_op != OP_NOP) regfile[exe_dst] <= wb_result;
      end else if (host_we && !busy) begin
        regfile[host_addr] <= host_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= instr_op;
      fifo_dst[wr_ptr]  <= instr_dst;
      fifo_src1[wr_ptr] <= instr_src1;
      fifo_src2[wr_ptr] <= instr_src2;
    end
    if (state == S_WAIT && exe_ready) wb_result <= exe_result;
  end

endmodule

// File: tb/tb_exec_scheduler.sv
// Scoreboard bench for exec_scheduler: a behavioural execution unit answers
// dispatches; expected results come from a bench-side register-file model.
module tb_exec_scheduler;
  localparam int WIDTH   = 8;
  localparam int SIZE    = 64;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;
  localparam int AW      = $clog2(SIZE);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instr_valid, instr_ready;
  logic [1:0]       instr_op;
  logic [AW-1:0]    instr_dst, instr_src1, instr_src2;
  logic             host_we;
  logic [AW-1:0]    host_addr;
  logic [WIDTH-1:0] host_wdata, host_rdata;
  logic             exe_en;
  logic [1:0]       exe_op;
  logic [WIDTH-1:0] exe_src1, exe_src2;
  logic [AW-1:0]    exe_dst;
  logic             exe_ready;
  logic [WIDTH-1:0] exe_result;
  logic             busy, done, err;
  logic [15:0]      retired;

  always #5 clk = ~clk;

  exec_scheduler #(.WIDTH(WIDTH), .SIZE(SIZE), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_dst(instr_dst), .instr_src1(instr_src1), .instr_src2(instr_src2),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .exe_en(exe_en), .exe_op(exe_op), .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dst(exe_dst),
    .exe_ready(exe_ready), .exe_result(exe_result),
    .busy(busy), .done(done), .retired(retired), .err(err)
  );

  typedef struct {
    logic [1:0]       op;
    logic [AW-1:0]    dst;
    logic [WIDTH-1:0] s1, s2, res;
    bit               abort;
  } sb_t;

  sb_t              sb[$];
  logic [WIDTH-1:0] model_rf [SIZE];
  int               n_checks = 0;
  int               n_errors = 0;
  int               exp_retired = 0;
  bit               stall = 1'b0;
  int               lat = 2;
  int               unit_cnt = 0;
  bit               unit_given = 1'b0;
  logic             en_prev = 1'b0;
  logic             err_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (op)
      2'b01:   return a * b;
      2'b10:   return a + b;
      2'b11:   return a - b;
      default: return '0;
    endcase
  endfunction

  // Execution unit: answers once, lat cycles into exe_en, unless stalled.
  initial begin
    exe_ready  = 1'b0;
    exe_result = '0;
    forever begin
      @(posedge clk); #1;
      if (exe_en) begin
        unit_cnt++;
        if (!stall && unit_cnt >= lat && !unit_given) begin
          exe_ready  = 1'b1;
          exe_result = alu(exe_op, exe_src1, exe_src2);
          unit_given = 1'b1;
        end else begin
          exe_ready = 1'b0;
        end
      end else begin
        unit_cnt   = 0;
        unit_given = 1'b0;
        exe_ready  = 1'b0;
      end
    end
  end

  // Monitor: dispatch fields, retirement order/count, abort bookkeeping.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (exe_en && !en_prev) begin
        check_val("disp_sb", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          check_val("disp_nonnop", 32'(exe_op != 2'b00), 1);
          check_val("disp_op", 32'(exe_op), 32'(sb[0].op));
          check_val("disp_src1", 32'(exe_src1), 32'(sb[0].s1));
          check_val("disp_src2", 32'(exe_src2), 32'(sb[0].s2));
          check_val("disp_dst", 32'(exe_dst), 32'(sb[0].dst));
        end
      end
      if (done) begin
        check_val("done_sb", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("done_not_aborted", 32'(e.abort), 0);
          check_val("done_retired", 32'(retired), 32'(exp_retired));
          exp_retired++;
        end
      end
      if (err && !err_prev) begin
        check_val("abort_sb", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("abort_expected", 32'(e.abort), 1);
        end
      end
      en_prev  = exe_en;
      err_prev = err;
    end
  end

  task automatic push_instr(input logic [1:0] op, input int dst, input int s1, input int s2,
                            input bit exp_acc, input bit exp_abort, input string tag);
    sb_t e;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_dst   = AW'(dst);
    instr_src1  = AW'(s1);
    instr_src2  = AW'(s2);
    check_val(tag, 32'(instr_ready), 32'(exp_acc));
    if (exp_acc) begin
      e.op    = op;
      e.dst   = AW'(dst);
      e.s1    = model_rf[s1];
      e.s2    = model_rf[s2];
      e.res   = alu(op, e.s1, e.s2);
      e.abort = exp_abort;
      if (op != 2'b00 && !exp_abort) model_rf[dst] = e.res;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic host_write(input int a, input logic [WIDTH-1:0] d, input bit idle);
    @(negedge clk);
    host_we    = 1'b1;
    host_addr  = AW'(a);
    host_wdata = d;
    check_val("hw_busy", 32'(busy), 32'(!idle));
    if (idle) model_rf[a] = d;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  task automatic check_reg(input int a);
    @(negedge clk);
    host_addr = AW'(a);
    #1;
    check_val($sformatf("r%0d", a), 32'(host_rdata), 32'(model_rf[a]));
  endtask

  task automatic wait_idle(input string tag);
    @(negedge clk);
    for (int i = 0; i < 600 && busy; i++) @(negedge clk);
    check_val(tag, 32'(busy), 0);
  endtask

  task automatic wait_en(input string tag);
    for (int i = 0; i < 30 && !exe_en; i++) @(negedge clk);
    check_val(tag, 32'(exe_en), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_dst = '0;
    instr_src1 = '0; instr_src2 = '0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < SIZE; i++) model_rf[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_exe_en", 32'(exe_en), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_retired", 32'(retired), 0);
    check_val("rst_ready", 32'(instr_ready), 1);
    check_val("rst_exe_op", 32'(exe_op), 0);
    @(negedge clk); rst_n = 1'b1;

    // Host setup and dependent add -> mul chain
    host_write(1, 8'd5, 1'b1);
    host_write(2, 8'd3, 1'b1);
    check_reg(1);
    check_reg(2);
    lat = 2; stall = 1'b0;
    push_instr(2'b10, 3, 1, 2, 1'b1, 1'b0, "acc_add");
    push_instr(2'b01, 4, 3, 2, 1'b1, 1'b0, "acc_mul");
    wait_idle("idle_chain");
    check_reg(3);
    check_reg(4);
    check_val("ret_chain", 32'(retired), 32'(exp_retired));

    // Minimum latency: done 4 negedges after accept, write visible one later
    host_addr = AW'(15);
    push_instr(2'b11, 15, 1, 2, 1'b1, 1'b0, "acc_lat");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); n++;
      if (done) break;
    end
    check_val("lat_done", 32'(n), 4);
    check_val("lat_prewrite", 32'(host_rdata), 0);
    @(negedge clk);
    check_val("lat_write", 32'(host_rdata), 32'(8'd2));
    wait_idle("idle_lat");

    // FIFO full behind a stalled dispatch
    stall = 1'b1;
    push_instr(2'b10, 5, 1, 2, 1'b1, 1'b0, "acc_blocker");
    wait_en("en_blocker");
    repeat (3) @(negedge clk);
    push_instr(2'b11, 6, 1, 2, 1'b1, 1'b0, "full_acc0");
    push_instr(2'b10, 7, 6, 6, 1'b1, 1'b0, "full_acc1");
    push_instr(2'b01, 8, 7, 2, 1'b1, 1'b0, "full_acc2");
    push_instr(2'b11, 9, 2, 1, 1'b1, 1'b0, "full_acc3");
    push_instr(2'b10, 10, 1, 1, 1'b0, 1'b0, "full_refuse");
    stall = 1'b0;
    wait_idle("idle_full");
    for (int r = 5; r <= 10; r++) check_reg(r);
    check_val("ret_full", 32'(retired), 32'(exp_retired));

    // Timeout abort, then a normal instruction proceeds
    stall = 1'b1;
    push_instr(2'b10, 11, 4, 1, 1'b1, 1'b1, "acc_tmo");
    wait_en("en_tmo");
    repeat (200) @(negedge clk);
    check_val("tmo_early", 32'(err), 0);
    for (int i = 0; i < 150 && !err; i++) @(negedge clk);
    check_val("tmo_err", 32'(err), 1);
    check_val("tmo_exe_en", 32'(exe_en), 0);
    check_val("tmo_busy", 32'(busy), 0);
    check_val("tmo_retired", 32'(retired), 32'(exp_retired));
    check_reg(11);
    stall = 1'b0;
    push_instr(2'b01, 12, 2, 2, 1'b1, 1'b0, "acc_after_tmo");
    wait_idle("idle_tmo");
    check_reg(12);
    check_val("tmo_err_sticky", 32'(err), 1);

    // NOP retires without a write; host write while busy is dropped
    push_instr(2'b00, 13, 0, 0, 1'b1, 1'b0, "acc_nop");
    host_write(13, 8'h77, 1'b0);
    wait_idle("idle_nop");
    check_reg(13);
    check_val("ret_nop", 32'(retired), 32'(exp_retired));

    // Reset while in WAIT
    stall = 1'b1;
    push_instr(2'b10, 14, 1, 2, 1'b1, 1'b0, "acc_rst");
    wait_en("en_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    check_val("rstw_exe_en", 32'(exe_en), 0);
    check_val("rstw_busy", 32'(busy), 0);
    check_val("rstw_retired", 32'(retired), 0);
    check_val("rstw_err", 32'(err), 0);
    check_val("rstw_done", 32'(done), 0);
    check_val("rstw_ready", 32'(instr_ready), 1);
    check_val("rstw_src1", 32'(exe_src1), 0);
    for (int i = 0; i < SIZE; i++) model_rf[i] = '0;
    exp_retired = 0;
    stall = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int r = 0; r < SIZE; r++) check_reg(r);

    // Operation after reset
    host_write(1, 8'd9, 1'b1);
    host_write(2, 8'd4, 1'b1);
    push_instr(2'b11, 3, 1, 2, 1'b1, 1'b0, "acc_post_rst");
    wait_idle("idle_post_rst");
    check_reg(3);
    check_val("ret_post_rst", 32'(retired), 32'(exp_retired));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
